fc_layer_engine: RTL
====================

Name: fc_layer_engine

Overview:
- Parametrised fully-connected layer engine for the MNIST streamline datapath. It is the successor of the fixed per-layer wrappers: one module instantiated once per FC layer.
- Contains:
  - its own sequencing FSM;
  - a MAC_NUM-lane MAC array;
  - requantise/ReLU/saturate logic;
  - an OUT_LEN-entry result buffer that the next layer reads.
- Input activations are fetched from the previous layer's buffer. Weights come from an external single-port ROM. Both have 1-cycle read latency.

Parameters:
- DATA_WIDTH, 8: signed activation/weight width.
- IN_LEN, 64: input vector length.
- OUT_LEN, 32: output vector length; must be a multiple of MAC_NUM.
- MAC_NUM, 16: parallel MAC lanes (output neurons per group).
- ACC_WIDTH, 24: signed accumulator width.
- COEFF, 17'h0015F: unsigned requantisation multiplier.
- COEFF_FRAC, 16: right-shift applied after the multiply.
- RELU, 1: 1 = apply ReLU; 0 = signed output (final layer).

Ports:
- clk_i in 1: clock.
- rstn_i in 1: reset; asynchronous, active-low.
- start_i in 1: single-cycle start pulse.
- busy_o out 1: high from the cycle after an accepted start until done_o.
- done_o out 1: one-cycle pulse when all outputs are written.
- prev_clear_o out 1: one-cycle pulse, coincident with done_o; the previous layer may reuse its buffer.
- x_en_o out 1: input read enable.
- x_addr_o out clog2(IN_LEN): input read address.
- x_data_i in DATA_WIDTH: input data, valid the cycle after x_en_o.
- w_en_o out 1: weight read enable.
- w_addr_o out clog2(IN_LEN*OUT_LEN/MAC_NUM): weight row address.
- w_data_i in MAC_NUM*DATA_WIDTH: weight row; lane k is bits [k*DW +: DW].
- rd_en_i in 1: result buffer read enable.
- rd_addr_i in clog2(OUT_LEN): result buffer read address.
- rd_data_o out DATA_WIDTH: result data, 1-cycle latency.
- clear_i in 1: invalidate all result entries.

Behaviour:
- Reset:
  - FSM returns to IDLE; accumulators and counters are zeroed.
  - All outputs go to 0, including rd_data_o.
  - Reset does not initialise result storage, but all valid bits are cleared.
- FSM states: IDLE, FETCH, DRAIN, WRITE, DONE.
  - IDLE: on start_i go to FETCH with group g=0. All accumulators are cleared on entry to FETCH.
  - FETCH: lasts IN_LEN cycles. Each cycle asserts x_en_o and w_en_o with x_addr_o=i and w_addr_o=g*IN_LEN+i, for i=0..IN_LEN-1.
  - Accumulation: a 1-cycle delayed valid accumulates acc[k] += x_data_i * w_lane[k]. The product is a signed full-width 2*DW value, sign-extended to ACC_WIDTH; accumulation wraps.
  - DRAIN: 1 cycle, in which the last product is accumulated.
  - WRITE: MAC_NUM cycles. Cycle k writes lane k's requantised value to entry g*MAC_NUM+k and sets its valid bit.
  - After WRITE: if g < OUT_LEN/MAC_NUM-1, increment g and go to FETCH (accumulators cleared); otherwise go to DONE.
  - DONE: 1 cycle; pulse done_o and prev_clear_o, then return to IDLE.
- Latency: with start_i sampled at edge 0, done_o is high in cycle G*(IN_LEN+1+MAC_NUM)+1, where G=OUT_LEN/MAC_NUM. For the defaults that is cycle 163.
- Requantisation:
  - p = acc * signed({1'b0,COEFF}).
  - q = p >>> COEFF_FRAC (arithmetic shift, floor).
  - If RELU=1 and q<0, q=0.
  - Saturate to [-2^(DW-1), 2^(DW-1)-1].
- Handshake and control:
  - start_i while busy is ignored.
  - x_en_o and w_en_o are low outside FETCH.
- Result buffer:
  - Registered read: rd_data_o = stored value if the entry is valid, else 0.
  - Reads are allowed at any time, including while busy.
  - Reading an entry being written in the same cycle returns its old value.
- clear_i:
  - Clears all valid bits in one cycle and is allowed while busy.
  - If clear_i and a write hit the same entry in the same cycle, the write wins (valid=1).
- Reset mid-operation: the run aborts, no done_o is produced, and the next start_i begins afresh.

Optional Feature:
- Macro: FC_ARGMAX_EN.
- When defined:
  - Adds ports argmax_o (clog2(OUT_LEN)) and argmax_valid_o (1).
  - During WRITE, a running maximum of the requantised values is tracked, reset at the start of each run.
  - Strict greater-than comparison, so ties keep the lowest index.
  - argmax_valid_o goes high with done_o and stays high until the next accepted start, clear_i, or reset.
  - argmax_o holds the index (reset value 0).
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package fc_pkg holds:
  - the FSM state enum (fc_state_t);
  - a requantise/saturate function parametrised by widths;
  - a clog2 helper.
- Sub-module fc_mac_lane: one signed accumulator with clear/enable, instantiated MAC_NUM times.
- FSM, requantisation and result buffer stay in the top module.

Test Plan:
- All x=1, all w=1, COEFF=1<<16, defaults → every output is 64; done_o at cycle 163; prev_clear_o coincides with done_o.
- x=127, w=127, COEFF=1<<16 → acc=1032256 → every output saturates to 127.
- x=1, w=-1, RELU=1 → all outputs 0. Same stimulus with RELU=0 → all outputs -64.
- start_i re-pulsed at cycles 10 and 100 → ignored; single done_o at 163, no address restart. Reset at cycle 50 → done_o never pulses; a fresh start completes at +163.
- Read entry 5 before a run → 0. Run, then read → value. clear_i → 0. clear_i in the same cycle as the write of entry 3 → entry 3 valid.
- FC_ARGMAX_EN, lane k weights = k: output 15 and output 31 both max, group-1 values larger → argmax_o=31. With all outputs equal → argmax_o=0.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully-connected layer engine.
// No logic of its own; functions are evaluated combinationally by users.
// No flow control here.
package fc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } fc_state_t;

  // Working width of the requantiser; wide enough for ACC_WIDTH + 17-bit coefficient.
  localparam int REQ_W = 64;

  // Address width for a table of 'value' entries, never narrower than one bit.
  function automatic int fc_clog2(input int value);
    int w;
    w = 1;
    for (int b = 1; b < 31; b++) begin
      if ((1 << b) < value) w = b + 1;
    end
    return w;
  endfunction

  // Scale by coeff, floor-shift by frac, optional ReLU, saturate to a dw-bit signed range.
  function automatic logic signed [31:0] fc_requant(
    input logic signed [REQ_W-1:0] acc,
    input logic [31:0]             coeff,
    input int                      frac,
    input int                      dw,
    input logic                    relu
  );
    logic signed [REQ_W-1:0] p;
    logic signed [REQ_W-1:0] q;
    logic signed [REQ_W-1:0] hi;
    logic signed [REQ_W-1:0] lo;
    p  = acc * $signed({32'd0, coeff});
    q  = p >>> frac;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (relu && (q < 0)) q = '0;
    if (q > hi)      q = hi;
    else if (q < lo) q = lo;
    return $signed(q[31:0]);
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One MAC lane: signed DWxDW product sign-extended and added into a wrapping accumulator.
// Latency: product lands in acc at the edge where en is sampled high.
// No backpressure; clr has priority over en.
module fc_mac_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext;

  assign prod     = a * b;
  assign prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};

  // Accumulate one product per enabled cycle; overflow wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    acc <= '0;
    else if (clr)  acc <= '0;
    else if (en)   acc <= acc + prod_ext;
  end

endmodule

// File: rtl/fc_layer_engine.sv
// FC layer: MAC_NUM-lane MAC array, requantise/ReLU/saturate, OUT_LEN-entry result buffer.
// Latency: done_o G*(IN_LEN+1+MAC_NUM)+1 cycles after start; buffer reads take 1 cycle.
// No backpressure: start_i ignored while busy; optional argmax via macro FC_ARGMAX_EN.
module fc_layer_engine
  import fc_pkg::*;
#(
  parameter int          DATA_WIDTH = 8,
  parameter int          IN_LEN     = 64,
  parameter int          OUT_LEN    = 32,
  parameter int          MAC_NUM    = 16,
  parameter int          ACC_WIDTH  = 24,
  parameter logic [16:0] COEFF      = 17'h0015F,
  parameter int          COEFF_FRAC = 16,
  parameter int          RELU       = 1
) (
  input  logic                                            clk_i,
  input  logic                                            rstn_i,
  input  logic                                            start_i,
  output logic                                            busy_o,
  output logic                                            done_o,
  output logic                                            prev_clear_o,
  output logic                                            x_en_o,
  output logic [fc_clog2(IN_LEN)-1:0]                     x_addr_o,
  input  logic [DATA_WIDTH-1:0]                           x_data_i,
  output logic                                            w_en_o,
  output logic [fc_clog2(IN_LEN*OUT_LEN/MAC_NUM)-1:0]     w_addr_o,
  input  logic [MAC_NUM*DATA_WIDTH-1:0]                   w_data_i,
  input  logic                                            rd_en_i,
  input  logic [fc_clog2(OUT_LEN)-1:0]                    rd_addr_i,
  output logic [DATA_WIDTH-1:0]                           rd_data_o,
  input  logic                                            clear_i
`ifdef FC_ARGMAX_EN
  ,
  output logic [fc_clog2(OUT_LEN)-1:0]                    argmax_o,
  output logic                                            argmax_valid_o
`endif
);

  localparam int GROUPS = OUT_LEN / MAC_NUM;
  localparam int XA_W   = fc_clog2(IN_LEN);
  localparam int WA_W   = fc_clog2(IN_LEN * GROUPS);
  localparam int OA_W   = fc_clog2(OUT_LEN);
  localparam int K_W    = fc_clog2(MAC_NUM);
  localparam int G_W    = fc_clog2(GROUPS);

  fc_state_t state, next_state;

  logic [XA_W-1:0] i_cnt;
  logic [K_W-1:0]  k_cnt;
  logic [G_W-1:0]  g_cnt;
  logic            mac_vld;
  logic            acc_clr;
  logic            wr_en;
  logic [OA_W-1:0] wr_addr;
  logic            i_last, k_last, g_last;

  logic signed [ACC_WIDTH-1:0]  acc [MAC_NUM];
  logic signed [ACC_WIDTH-1:0]  acc_sel;
  logic signed [31:0]           q32;
  logic signed [DATA_WIDTH-1:0] q_dw;
  logic                         unused_q_hi;

  logic [DATA_WIDTH-1:0] mem [OUT_LEN];
  logic [OUT_LEN-1:0]    valid;

  assign i_last = (i_cnt == XA_W'(IN_LEN - 1));
  assign k_last = (k_cnt == K_W'(MAC_NUM - 1));
  assign g_last = (g_cnt == G_W'(GROUPS - 1));

  assign x_addr_o = i_cnt;
  assign w_addr_o = WA_W'(g_cnt) * WA_W'(IN_LEN) + WA_W'(i_cnt);
  assign wr_addr  = OA_W'(g_cnt) * OA_W'(MAC_NUM) + OA_W'(k_cnt);

  // State register; reset aborts any run in progress.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= ST_IDLE;
    else         state <= next_state;
  end

  // Next-state and per-state strobes; accumulators clear on every entry to FETCH.
  always_comb begin
    next_state   = state;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    prev_clear_o = 1'b0;
    x_en_o       = 1'b0;
    w_en_o       = 1'b0;
    wr_en        = 1'b0;
    acc_clr      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          next_state = ST_FETCH;
          acc_clr    = 1'b1;
        end
      end
      ST_FETCH: begin
        busy_o = 1'b1;
        x_en_o = 1'b1;
        w_en_o = 1'b1;
        if (i_last) next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy_o     = 1'b1;
        next_state = ST_WRITE;
      end
      ST_WRITE: begin
        busy_o = 1'b1;
        wr_en  = 1'b1;
        if (k_last) begin
          if (g_last) begin
            next_state = ST_DONE;
          end else begin
            next_state = ST_FETCH;
            acc_clr    = 1'b1;
          end
        end
      end
      ST_DONE: begin
        busy_o       = 1'b1;
        done_o       = 1'b1;
        prev_clear_o = 1'b1;
        next_state   = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Input index, write lane and group counters plus the 1-cycle read-latency valid.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      i_cnt   <= '0;
      k_cnt   <= '0;
      g_cnt   <= '0;
      mac_vld <= 1'b0;
    end else begin
      mac_vld <= (state == ST_FETCH);
      case (state)
        ST_IDLE: begin
          i_cnt <= '0;
          k_cnt <= '0;
          g_cnt <= '0;
        end
        ST_FETCH: i_cnt <= i_last ? '0 : i_cnt + 1'b1;
        ST_WRITE: begin
          if (k_last) begin
            k_cnt <= '0;
            g_cnt <= g_last ? '0 : g_cnt + 1'b1;
          end else begin
            k_cnt <= k_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < MAC_NUM; k++) begin : g_lane
    fc_mac_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_lane (
      .clk   (clk_i),
      .rst_n (rstn_i),
      .clr   (acc_clr),
      .en    (mac_vld),
      .a     ($signed(x_data_i)),
      .b     ($signed(w_data_i[k*DATA_WIDTH +: DATA_WIDTH])),
      .acc   (acc[k])
    );
  end

  assign acc_sel     = acc[k_cnt];
  assign q32         = fc_requant({{(REQ_W-ACC_WIDTH){acc_sel[ACC_WIDTH-1]}}, acc_sel},
                                  32'(COEFF), COEFF_FRAC, DATA_WIDTH, (RELU != 0));
  assign q_dw        = q32[DATA_WIDTH-1:0];
  assign unused_q_hi = &{1'b0, q32[31:DATA_WIDTH]};

  // Result storage carries no reset; the valid bits decide what a reader sees.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= q_dw;
  end

  // Valid bits: clear_i wipes all, a same-cycle write to an entry still marks it valid.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid <= '0;
    end else begin
      if (clear_i) valid <= '0;
      if (wr_en)   valid[wr_addr] <= 1'b1;
    end
  end

  // Registered read port; invalid entries read as zero, same-cycle writes return old data.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)      rd_data_o <= '0;
    else if (rd_en_i) rd_data_o <= valid[rd_addr_i] ? mem[rd_addr_i] : '0;
  end

`ifdef FC_ARGMAX_EN
  logic signed [DATA_WIDTH-1:0] max_val;
  logic                         have_max;

  // Running maximum over the run's written values; strict compare keeps the lowest index on ties.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      max_val        <= '0;
      have_max       <= 1'b0;
      argmax_o       <= '0;
      argmax_valid_o <= 1'b0;
    end else begin
      if (state == ST_IDLE && start_i) begin
        have_max       <= 1'b0;
        argmax_valid_o <= 1'b0;
      end else if (wr_en && (!have_max || (q_dw > max_val))) begin
        have_max <= 1'b1;
        max_val  <= q_dw;
        argmax_o <= wr_addr;
      end
      if (clear_i)              argmax_valid_o <= 1'b0;
      if (next_state == ST_DONE) argmax_valid_o <= 1'b1;
    end
  end
`endif

endmodule
